// File: rtl/tick_delay_timer.sv
// Delay timer that counts clk cycles or timebase tick strobes (1us/1ms/1s).
// Supports one-shot and periodic modes, abort, and flags a start issued while busy.
module tick_delay_timer #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_1us,
    input  logic                 tick_1ms,
    input  logic                 tick_1s,
    input  logic                 start,
    input  logic [1:0]           unit,
    input  logic [CNT_WIDTH-1:0] count,
    input  logic                 periodic,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] remain,
    output logic                 start_err
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [1:0] UNIT_CLK = 2'd0;
    localparam logic [1:0] UNIT_US  = 2'd1;
    localparam logic [1:0] UNIT_MS  = 2'd2;
    localparam logic [1:0] UNIT_S   = 2'd3;

    logic [0:0]           state;
    logic [0:0]           state_nxt;
    logic [1:0]           unit_q;
    logic [1:0]           unit_nxt;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 periodic_q;
    logic                 periodic_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;
    logic [CNT_WIDTH-1:0] remain_nxt;
    logic                 start_err_nxt;
    logic                 tick_sel_c;

    // Tick source follows the latched unit, never the live input.
    always_comb begin
        tick_sel_c = 1'b0;
        case (unit_q)
            UNIT_CLK: tick_sel_c = 1'b1;
            UNIT_US:  tick_sel_c = tick_1us;
            UNIT_MS:  tick_sel_c = tick_1ms;
            UNIT_S:   tick_sel_c = tick_1s;
            default:  tick_sel_c = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output logic; abort overrides everything, including expiry.
    always_comb begin
        state_nxt     = state;
        unit_nxt      = unit_q;
        count_nxt     = count_q;
        periodic_nxt  = periodic_q;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        remain_nxt    = remain;
        start_err_nxt = 1'b0;

        if (abort) begin
            state_nxt  = ST_IDLE;
            busy_nxt   = 1'b0;
            remain_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        unit_nxt     = unit;
                        count_nxt    = count;
                        periodic_nxt = periodic;
                        if (count == '0) begin
                            // Zero-length delay expires immediately, always one-shot.
                            done_nxt   = 1'b1;
                            busy_nxt   = 1'b0;
                            remain_nxt = '0;
                        end else begin
                            state_nxt  = ST_RUN;
                            busy_nxt   = 1'b1;
                            remain_nxt = count;
                        end
                    end
                end
                ST_RUN: begin
                    start_err_nxt = start;
                    if (tick_sel_c) begin
                        if (remain > CNT_WIDTH'(1)) begin
                            remain_nxt = remain - CNT_WIDTH'(1);
                        end else begin
                            done_nxt = 1'b1;
                            if (periodic_q) begin
                                remain_nxt = count_q;
                            end else begin
                                state_nxt  = ST_IDLE;
                                busy_nxt   = 1'b0;
                                remain_nxt = '0;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    busy_nxt   = 1'b0;
                    remain_nxt = '0;
                end
            endcase
        end
    end

    // Registered outputs and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_q     <= 2'd0;
            count_q    <= '0;
            periodic_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            remain     <= '0;
            start_err  <= 1'b0;
        end else begin
            unit_q     <= unit_nxt;
            count_q    <= count_nxt;
            periodic_q <= periodic_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            remain     <= remain_nxt;
            start_err  <= start_err_nxt;
        end
    end

endmodule

// File: tb/tb_tick_delay_timer.sv
// Directed self-checking bench for tick_delay_timer.
module tb_tick_delay_timer;

    localparam int unsigned CW = 16;

    logic          clk;
    logic          rst_n;
    logic          tick_1us;
    logic          tick_1ms;
    logic          tick_1s;
    logic          start;
    logic [1:0]    unit;
    logic [CW-1:0] count;
    logic          periodic;
    logic          abort;
    logic          busy;
    logic          done;
    logic [CW-1:0] remain;
    logic          start_err;

    int n_tests = 0;
    int n_fail  = 0;

    tick_delay_timer #(.CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_1us  (tick_1us),
        .tick_1ms  (tick_1ms),
        .tick_1s   (tick_1s),
        .start     (start),
        .unit      (unit),
        .count     (count),
        .periodic  (periodic),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .remain    (remain),
        .start_err (start_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] u, input logic [CW-1:0] c, input logic p);
        unit     = u;
        count    = c;
        periodic = p;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    initial begin
        logic saw_done;
        rst_n = 1'b0; tick_1us = 0; tick_1ms = 0; tick_1s = 0;
        start = 0; unit = 0; count = '0; periodic = 0; abort = 0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_remain", 32'(remain), 0);
        check("rst_err", 32'(start_err), 0);
        rst_n = 1'b1;
        step();

        // Reset mid-delay clears outputs at once and no done follows.
        req(2'd0, CW'(10), 1'b0);
        step();
        check("mid_busy_pre", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_remain", 32'(remain), 0);
        check("arst_done", 32'(done), 0);
        step();
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (done) saw_done = 1'b1;
        end
        check("arst_no_done", 32'(saw_done), 0);

        // Clock-cycle unit, count 3.
        req(2'd0, CW'(3), 1'b0);
        check("u0_busy1", 32'(busy), 1);
        check("u0_rem3", 32'(remain), 3);
        step();
        check("u0_rem2", 32'(remain), 2);
        step();
        check("u0_rem1", 32'(remain), 1);
        check("u0_nodone", 32'(done), 0);
        step();
        check("u0_done", 32'(done), 1);
        check("u0_busy0", 32'(busy), 0);
        check("u0_rem0", 32'(remain), 0);
        step();
        check("u0_done_drop", 32'(done), 0);

        // Microsecond unit, count 5; tick coincident with start is ignored.
        tick_1us = 1'b1;
        req(2'd1, CW'(5), 1'b0);
        tick_1us = 1'b0;
        check("us_rem5", 32'(remain), 5);
        for (int k = 1; k <= 5; k++) begin
            repeat (11) step();
            check("us_gap_nodone", 32'(done), 0);
            tick_1us = 1'b1;
            step();
            tick_1us = 1'b0;
            if (k < 5) begin
                check("us_rem", 32'(remain), 32'(5 - k));
            end else begin
                check("us_done", 32'(done), 1);
                check("us_busy0", 32'(busy), 0);
            end
        end
        step();
        check("us_done_once", 32'(done), 0);

        // Zero count, one-shot and periodic.
        req(2'd2, CW'(0), 1'b0);
        check("z_done", 32'(done), 1);
        check("z_busy", 32'(busy), 0);
        step();
        check("z_done_drop", 32'(done), 0);
        req(2'd2, CW'(0), 1'b1);
        check("zp_done", 32'(done), 1);
        check("zp_busy", 32'(busy), 0);
        step();
        check("zp_done_drop", 32'(done), 0);
        check("zp_busy2", 32'(busy), 0);

        // Periodic ms timer, count 2, then abort.
        req(2'd2, CW'(2), 1'b1);
        check("p_rem2", 32'(remain), 2);
        for (int k = 1; k <= 4; k++) begin
            repeat (4) step();
            tick_1ms = 1'b1;
            step();
            tick_1ms = 1'b0;
            check("p_done", 32'(done), (k % 2 == 0) ? 1 : 0);
            check("p_busy", 32'(busy), 1);
            check("p_rem", 32'(remain), (k % 2 == 0) ? 2 : 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("p_abort_busy", 32'(busy), 0);
        check("p_abort_rem", 32'(remain), 0);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            repeat (4) step();
            tick_1ms = 1'b1;
            step();
            tick_1ms = 1'b0;
            if (done) saw_done = 1'b1;
        end
        check("p_no_done_after_abort", 32'(saw_done), 0);

        // Start during RUN: start_err, latched request unchanged.
        req(2'd0, CW'(8), 1'b0);
        step();
        check("c1_rem7", 32'(remain), 7);
        req(2'd1, CW'(2), 1'b0);
        check("c1_err", 32'(start_err), 1);
        check("c1_rem6", 32'(remain), 6);
        step();
        check("c1_err_drop", 32'(start_err), 0);
        check("c1_rem5", 32'(remain), 5);
        repeat (4) step();
        check("c1_rem1", 32'(remain), 1);
        step();
        check("c1_done", 32'(done), 1);
        step();

        // Abort in the expiry cycle suppresses done.
        req(2'd0, CW'(2), 1'b0);
        step();
        check("c2_rem1", 32'(remain), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("c2_no_done", 32'(done), 0);
        check("c2_busy", 32'(busy), 0);
        step();
        check("c2_no_done_late", 32'(done), 0);

        // Start with abort while idle: nothing accepted.
        abort = 1'b1;
        req(2'd0, CW'(4), 1'b0);
        abort = 1'b0;
        check("c3_busy", 32'(busy), 0);
        check("c3_err", 32'(start_err), 0);
        check("c3_rem", 32'(remain), 0);
        step();
        check("c3_busy_late", 32'(busy), 0);

        // New start in the done cycle is accepted.
        req(2'd0, CW'(1), 1'b0);
        check("c4_busy", 32'(busy), 1);
        step();
        check("c4_done", 32'(done), 1);
        req(2'd0, CW'(2), 1'b0);
        check("c4_rebusy", 32'(busy), 1);
        check("c4_rem2", 32'(remain), 2);
        check("c4_done_drop", 32'(done), 0);
        check("c4_err", 32'(start_err), 0);
        step();
        check("c4_rem1", 32'(remain), 1);
        step();
        check("c4_done2", 32'(done), 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
